// File: rtl/rr_arbiter4_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter4_if
// Bundle of the request/grant signals shared by the arbiter and its requesters.
//   req      : 4-bit request vector, bit k = requester k wants the resource
//   gnt      : registered one-hot grant, all-zero when idle
//   gnt_idx  : binary index of the current grantee (meaningful when gnt_vld=1)
//   gnt_vld  : high while any grant is active
//   hold_cnt : cycles elapsed in the current tenure (observability)
// Modports:
//   master : arbiter side (consumes req, drives the grant outputs)
//   slave  : requester side (drives req, observes the grant outputs)
// -----------------------------------------------------------------------------
interface rr_arbiter4_if #(
  parameter int CNT_W = 4
);
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       gnt_idx;
  logic             gnt_vld;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    input  req,
    output gnt, gnt_idx, gnt_vld, hold_cnt
  );

  modport slave (
    output req,
    input  gnt, gnt_idx, gnt_vld, hold_cnt
  );
endinterface

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
// Four-way round-robin arbiter with a bounded grant tenure. A grantee keeps the
// resource until it drops its request, or until it has held it for MAX_HOLD
// cycles while another requester is waiting. Hand-overs happen on the same edge
// as the release, so there is no idle bubble between tenures.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : rr_arbiter4_if.master (req in; gnt, gnt_idx, gnt_vld, hold_cnt out)
// Parameters:
//   MAX_HOLD : max consecutive cycles of one tenure under contention (1..15)
//   CNT_W    : hold-counter width, 2**CNT_W > MAX_HOLD
// -----------------------------------------------------------------------------
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter4_if.master  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  // First set bit of req searched in the order base+1, base+2, base+3, base.
  // The loop walks the order backwards so the earliest candidate is the one
  // left standing.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] idx);
    decode = 4'b0001 << idx;
  endfunction

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_gnt_idx;
  logic [3:0]       r_gnt;
  logic             r_gnt_vld;
  logic [CNT_W-1:0] r_hold_cnt;

  logic [3:0] w_others;
  logic [1:0] w_win_idle;
  logic [1:0] w_win_busy;
  logic       w_release;
  logic       w_timeout;

  // Requests other than the current grantee; the grantee is masked out so a
  // forced hand-over can never land back on it.
  assign w_others   = bus.req & ~decode(r_gnt_idx);
  assign w_win_idle = rr_pick(bus.req, r_ptr);
  assign w_win_busy = rr_pick(w_others, r_gnt_idx);
  assign w_release  = ~bus.req[r_gnt_idx];
  assign w_timeout  = (r_hold_cnt == HOLD_LAST) && (|w_others);

  // NOTE: every register below is assigned with <= so all of them update from
  // the same pre-edge values; blocking assignments here would let later lines
  // see already-updated state and break the single-edge hand-over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= 2'b11;
      r_gnt_idx  <= 2'b00;
      r_gnt      <= 4'b0000;
      r_gnt_vld  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_gnt_idx  <= w_win_idle;
            r_gnt      <= decode(w_win_idle);
            r_gnt_vld  <= 1'b1;
            r_hold_cnt <= '0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (w_release || w_timeout) begin
            // Release and timeout share one path: either way the pointer moves
            // to the outgoing grantee and a waiting requester takes over.
            r_ptr      <= r_gnt_idx;
            r_hold_cnt <= '0;
            if (|w_others) begin
              r_gnt_idx <= w_win_busy;
              r_gnt     <= decode(w_win_busy);
            end else begin
              r_gnt     <= 4'b0000;
              r_gnt_vld <= 1'b0;
              r_state   <= IDLE;
            end
          end else if (r_hold_cnt != HOLD_LAST) begin
            // Saturates when nobody else is asking, so a lone grantee never
            // sees the counter wrap.
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.gnt_idx  = r_gnt_idx;
  assign bus.gnt_vld  = r_gnt_vld;
  assign bus.hold_cnt = r_hold_cnt;

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin arbiter that shares one 4-way resource between four requesters.
- Internally produces a 2-bit grant index and decodes it to a registered one-hot grant vector.
- Each grant drives a one-hot select bus.
- Grant tenure is limited by a hold timer so no requester can starve the others.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester keeps the grant while another is waiting (legal range 1..15).
- CNT_W, 4, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit k = requester k wants the resource.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- gnt_idx  output  2  binary index of current grantee; valid only when gnt_vld=1.
- gnt_vld  output  1  high while any grant is active.
- hold_cnt  output  CNT_W  cycles elapsed in the current tenure (debug/observability).

Behaviour:
- Reset (async assert, takes effect immediately): gnt=4'b0000, gnt_idx=2'b00, gnt_vld=0, hold_cnt=0, state=IDLE, last-grant pointer ptr=2'b11 (requester 0 has top priority after reset).
- Search order: ptr+1, ptr+2, ptr+3, ptr (mod 4); the first set req bit wins.
- gnt is always the decode of gnt_idx: 00->0001, 01->0010, 10->0100, 11->1000, gated by gnt_vld.
- States: IDLE, BUSY.
- IDLE:
  - req==0 -> stay in IDLE.
  - Otherwise, at the next edge: winner W becomes gnt_idx, gnt_vld=1, hold_cnt=0, state=BUSY.
  - Latency: a req sampled at edge N yields gnt at edge N (visible in cycle N+1). No combinational path from req to gnt.
- BUSY (grantee G=gnt_idx):
  - Release: req[G]==0.
    - If another req is set: hand over at the same edge to the next RR winner searched from G+1. No bubble, hold_cnt=0, ptr=G.
    - If no req is set: gnt=0, gnt_vld=0, ptr=G, state=IDLE.
  - Timeout: req[G]==1, hold_cnt==MAX_HOLD-1, and any other req set -> forced handover to the next RR winner from G+1, hold_cnt=0, ptr=G. G must re-arbitrate normally.
  - Timeout with no competitor: G keeps the grant; hold_cnt saturates at MAX_HOLD-1 and does not wrap.
  - Otherwise: hold, hold_cnt+1.
- Simultaneous release and timeout: the release rule applies; the result is identical.
- gnt is never more than one-hot; a grantee is never re-granted at a handover edge while another request is pending.
- Reset mid-tenure: all outputs clear asynchronously. After deassert, arbitration restarts from ptr=3.
- X/Z on req is not supported. The behaviour is undefined and the bench does not drive it.

Test Plan:
- After reset, req=4'b1111 held -> gnt is 0001 for 8 cycles, then 0010, 0100, 1000, 0001, each for 8 cycles (MAX_HOLD=8).
- req=4'b0100 single pulse train: assert at edge 5, drop at edge 9 -> gnt=0100 during cycles 6-9, gnt=0000 from cycle 10, then ptr=2 (next req=1111 grants 1000 first).
- Zero-bubble handover: gnt=0001 active, req goes 0001->0110 in one cycle -> next edge gnt=0010, no all-zero cycle, hold_cnt=0.
- Lone requester: req=4'b1000 held 20 cycles -> gnt stays 1000 throughout, hold_cnt saturates at 7, no drop.
- Async reset: assert rst mid-cycle during gnt=0100, hold_cnt=3 -> gnt=0000, gnt_vld=0, hold_cnt=0 before the next edge. After deassert, req=1111 gives gnt=0001.
- One-hot assertion: random req for 10k cycles -> $countones(gnt)<=1 every cycle, gnt==decode(gnt_idx) whenever gnt_vld=1, and no requester waits more than 3*MAX_HOLD+3 cycles.
